// File: rtl/spike_rate_decoder.sv
// Spike rate and inter-spike-interval decoder for a single LIF spike line.
// Counts rising-edge spike events per programmable window and times the gaps between them.
module spike_rate_decoder #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8,
    parameter int ISI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    logic             spk_d;
    logic             started;
    logic             seen;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] len_new;
    logic [WIN_W-1:0] len_eff;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [ISI_W-1:0] isi_tmr;
    logic             spk_event;
    logic             win_last;

    assign spk_event = en & spike_in & ~spk_d;
    assign len_new   = (window_len == '0) ? WIN_ONE : window_len;
    // The very first window takes its length straight from the input.
    assign len_eff   = started ? len_q : len_new;
    assign win_last  = en & (win_cnt == (len_eff - WIN_ONE));
    assign cnt_next  = (spk_event && spk_cnt != CNT_MAX) ?
                       spk_cnt + 1'b1 : spk_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spk_d      <= 1'b0;
            started    <= 1'b0;
            seen       <= 1'b0;
            win_cnt    <= '0;
            len_q      <= WIN_ONE;
            spk_cnt    <= '0;
            isi_tmr    <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            isi_out    <= '0;
            isi_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            spk_d      <= spike_in;
            rate_valid <= 1'b0;
            isi_valid  <= 1'b0;
            if (en) begin
                started <= 1'b1;
                if (!started) begin
                    len_q <= len_new;
                end
                if (win_last) begin
                    rate_out   <= cnt_next;
                    rate_valid <= 1'b1;
                    spk_cnt    <= '0;
                    win_cnt    <= '0;
                    len_q      <= len_new;
                    if (cnt_next == CNT_MAX) begin
                        overflow <= 1'b1;
                    end
                end else begin
                    spk_cnt <= cnt_next;
                    win_cnt <= win_cnt + WIN_ONE;
                end
                if (spk_event) begin
                    isi_tmr <= ISI_W'(1);
                    seen    <= 1'b1;
                    if (seen) begin
                        isi_out   <= isi_tmr;
                        isi_valid <= 1'b1;
                        if (isi_tmr == ISI_MAX) begin
                            overflow <= 1'b1;
                        end
                    end
                end else if (isi_tmr != ISI_MAX) begin
                    isi_tmr <= isi_tmr + 1'b1;
                end
            end
        end
    end

endmodule
